// File: rtl/router_fsm_np.sv
// Control FSM for a 1xN packet router: header decode, load sequencing, full stalls, soft resets, drop of bad addresses.
// Optional macro ROUTER_WAIT_TIMEOUT_EN bounds the WAIT_TILL_EMPTY stay to WAIT_TIMEOUT cycles before dropping.
module router_fsm_np #(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  output logic                 busy,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 write_enb_reg,
  output logic                 rst_int_reg,
  output logic [NUM_PORTS-1:0] dest_sel,
  output logic                 pkt_drop
);

  localparam logic [3:0] DECODE_ADDRESS     = 4'd0;
  localparam logic [3:0] LOAD_FIRST_DATA    = 4'd1;
  localparam logic [3:0] WAIT_TILL_EMPTY    = 4'd2;
  localparam logic [3:0] LOAD_DATA          = 4'd3;
  localparam logic [3:0] FIFO_FULL_STATE    = 4'd4;
  localparam logic [3:0] LOAD_AFTER_FULL    = 4'd5;
  localparam logic [3:0] LOAD_PARITY        = 4'd6;
  localparam logic [3:0] CHECK_PARITY_ERROR = 4'd7;
  localparam logic [3:0] DROP_PACKET        = 4'd8;

  logic [3:0]           state_reg;
  logic [3:0]           state_next;
  logic [NUM_PORTS-1:0] dest_sel_reg;
  logic                 pkt_drop_reg;
  logic [31:0]          addr_ext;
  logic                 addr_valid;
  logic [NUM_PORTS-1:0] addr_onehot;
  logic                 hdr_empty;
  logic                 dest_empty;
  logic                 soft_hit;
  logic                 wait_expired;

  // Out-of-range shifts give all zeros, so an invalid address never selects a port.
  assign addr_ext    = 32'(data_in);
  assign addr_valid  = addr_ext < 32'(NUM_PORTS);
  assign addr_onehot = NUM_PORTS'(1) << data_in;
  assign hdr_empty   = |(fifo_empty & addr_onehot);
  assign dest_empty  = |(fifo_empty & dest_sel_reg);
  assign soft_hit    = |(soft_reset & dest_sel_reg);

`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_reg;

  // Held at zero outside WAIT_TILL_EMPTY, so it is zero on every entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_reg <= '0;
    end else if (state_reg != WAIT_TILL_EMPTY) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  assign wait_expired = (wait_cnt_reg == CNT_W'(WAIT_TIMEOUT - 1));
`else
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          if (!addr_valid)   state_next = DROP_PACKET;
          else if (hdr_empty) state_next = LOAD_FIRST_DATA;
          else               state_next = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_next = LOAD_DATA;
      WAIT_TILL_EMPTY: begin
        if (dest_empty)        state_next = LOAD_FIRST_DATA;
        else if (wait_expired) state_next = DROP_PACKET;
      end
      LOAD_DATA: begin
        if (fifo_full)       state_next = FIFO_FULL_STATE;
        else if (!pkt_valid) state_next = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_next = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_next = DECODE_ADDRESS;
        else if (low_pkt_valid) state_next = LOAD_PARITY;
        else                    state_next = LOAD_DATA;
      end
      LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        if (fifo_full) state_next = FIFO_FULL_STATE;
        else           state_next = DECODE_ADDRESS;
      end
      DROP_PACKET: begin
        if (!pkt_valid) state_next = DECODE_ADDRESS;
      end
      default: state_next = DECODE_ADDRESS;
    endcase
    // A soft reset of the selected FIFO abandons the packet in any active load state.
    if (soft_hit && state_reg != DECODE_ADDRESS && state_reg != DROP_PACKET) begin
      state_next = DECODE_ADDRESS;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= DECODE_ADDRESS;
      dest_sel_reg <= '0;
      pkt_drop_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pkt_drop_reg <= (state_next == DROP_PACKET) && (state_reg != DROP_PACKET);
      if (state_reg == DECODE_ADDRESS && pkt_valid && addr_valid) begin
        dest_sel_reg <= addr_onehot;
      end
    end
  end

  assign detect_add    = (state_reg == DECODE_ADDRESS);
  assign lfd_state     = (state_reg == LOAD_FIRST_DATA);
  assign ld_state      = (state_reg == LOAD_DATA);
  assign laf_state     = (state_reg == LOAD_AFTER_FULL);
  assign full_state    = (state_reg == FIFO_FULL_STATE);
  assign rst_int_reg   = (state_reg == CHECK_PARITY_ERROR);
  assign busy          = (state_reg == LOAD_FIRST_DATA) || (state_reg == WAIT_TILL_EMPTY) ||
                         (state_reg == FIFO_FULL_STATE) || (state_reg == LOAD_AFTER_FULL) ||
                         (state_reg == LOAD_PARITY)     || (state_reg == CHECK_PARITY_ERROR);
  assign write_enb_reg = (state_reg == LOAD_DATA) || (state_reg == LOAD_AFTER_FULL) ||
                         (state_reg == LOAD_PARITY);
  assign dest_sel      = dest_sel_reg;
  assign pkt_drop      = pkt_drop_reg;

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed bench for router_fsm_np (3 ports): state-flag vectors and dest_sel checked after every edge.
module tb_router_fsm_np;

`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam int WT     = 4;
  localparam int WAIT_N = 4;
`else
  localparam int WT     = 64;
  localparam int WAIT_N = 5;
`endif

  // Flag order: busy, detect_add, lfd, ld, laf, full, write_enb, rst_int
  localparam logic [7:0] S_DA   = 8'b0100_0000;
  localparam logic [7:0] S_LFD  = 8'b1010_0000;
  localparam logic [7:0] S_WTE  = 8'b1000_0000;
  localparam logic [7:0] S_LD   = 8'b0001_0010;
  localparam logic [7:0] S_FFS  = 8'b1000_0100;
  localparam logic [7:0] S_LAF  = 8'b1000_1010;
  localparam logic [7:0] S_LP   = 8'b1000_0010;
  localparam logic [7:0] S_CPE  = 8'b1000_0001;
  localparam logic [7:0] S_DROP = 8'b0000_0000;

  logic       clock = 1'b0;
  logic       reset, pkt_valid, parity_done, low_pkt_valid, fifo_full;
  logic [1:0] data_in;
  logic [2:0] fifo_empty, soft_reset;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, pkt_drop;
  logic [2:0] dest_sel;

  int checks = 0;
  int errors = 0;

  router_fsm_np #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(WT)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .soft_reset(soft_reset), .busy(busy), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .dest_sel(dest_sel),
    .pkt_drop(pkt_drop)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s val=%h", tag, got);
    end
  endtask

  // Advance one edge and compare the flag vector plus pkt_drop.
  task automatic step(input string tag, input logic [7:0] exp_state, input logic exp_drop);
    @(posedge clock);
    #1;
    check(tag, 32'({busy, detect_add, lfd_state, ld_state, laf_state, full_state,
                    write_enb_reg, rst_int_reg, pkt_drop}), 32'({exp_state, exp_drop}));
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0;
    low_pkt_valid = 1'b0; fifo_full = 1'b0; fifo_empty = 3'b111; soft_reset = 3'b000;

    step("reset_state", S_DA, 1'b0);
    check("reset_dest_sel", 32'(dest_sel), 32'd0);
    reset = 1'b0;

    // Normal packet to port 1
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b010;
    step("p1_lfd", S_LFD, 1'b0);
    check("p1_dest_sel", 32'(dest_sel), 32'b010);
    data_in = 2'd0;
    step("p1_ld1", S_LD, 1'b0);
    step("p1_ld2", S_LD, 1'b0);
    pkt_valid = 1'b0;
    step("p1_lp", S_LP, 1'b0);
    step("p1_cpe", S_CPE, 1'b0);
    step("p1_da", S_DA, 1'b0);

    // Full stall to port 0, then full together with pkt_valid low, then parity_done+low_pkt_valid
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 3'b001;
    step("p2_lfd", S_LFD, 1'b0);
    check("p2_dest_sel", 32'(dest_sel), 32'b001);
    step("p2_ld", S_LD, 1'b0);
    fifo_full = 1'b1;
    step("p2_ffs1", S_FFS, 1'b0);
    step("p2_ffs2", S_FFS, 1'b0);
    fifo_full = 1'b0;
    step("p2_laf", S_LAF, 1'b0);
    step("p2_ld_again", S_LD, 1'b0);
    fifo_full = 1'b1; pkt_valid = 1'b0;
    step("p2_full_beats_pv", S_FFS, 1'b0);
    fifo_full = 1'b0;
    step("p2_laf2", S_LAF, 1'b0);
    parity_done = 1'b1; low_pkt_valid = 1'b1;
    step("p2_pdone_wins", S_DA, 1'b0);
    parity_done = 1'b0; low_pkt_valid = 1'b0;

    // Invalid address 3 is dropped; dest_sel keeps the previous port
    pkt_valid = 1'b1; data_in = 2'd3; fifo_empty = 3'b111;
    step("drop_entry", S_DROP, 1'b1);
    check("drop_dest_hold", 32'(dest_sel), 32'b001);
    step("drop_hold1", S_DROP, 1'b0);
    step("drop_hold2", S_DROP, 1'b0);
    step("drop_hold3", S_DROP, 1'b0);
    pkt_valid = 1'b0;
    step("drop_exit", S_DA, 1'b0);

    // Wait for FIFO 2 to empty
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
    step("wait_1", S_WTE, 1'b0);
    check("wait_dest_sel", 32'(dest_sel), 32'b100);
    for (int i = 2; i <= WAIT_N; i++) begin
      step($sformatf("wait_%0d", i), S_WTE, 1'b0);
    end
    fifo_empty = 3'b111;
    step("wait_lfd", S_LFD, 1'b0);
    step("wait_ld", S_LD, 1'b0);
    pkt_valid = 1'b0; soft_reset = 3'b100;
    step("srst_beats_pv", S_DA, 1'b0);
    soft_reset = 3'b000;

    // Soft reset selectivity on port 0, then hard reset in FFS
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 3'b001;
    step("s5_lfd", S_LFD, 1'b0);
    step("s5_ld", S_LD, 1'b0);
    soft_reset = 3'b010;
    step("s5_other_srst", S_LD, 1'b0);
    soft_reset = 3'b001;
    step("s5_own_srst", S_DA, 1'b0);
    soft_reset = 3'b000;
    step("s5_lfd2", S_LFD, 1'b0);
    step("s5_ld2", S_LD, 1'b0);
    fifo_full = 1'b1;
    step("s5_ffs", S_FFS, 1'b0);
    reset = 1'b1; pkt_valid = 1'b0;
    step("s5_hard_reset", S_DA, 1'b0);
    check("s5_reset_dest", 32'(dest_sel), 32'd0);
    reset = 1'b0; fifo_full = 1'b0;

`ifdef ROUTER_WAIT_TIMEOUT_EN
    // FIFO never empties: drop after exactly WT wait cycles
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
    for (int i = 1; i <= WT; i++) begin
      step($sformatf("to_wait_%0d", i), S_WTE, 1'b0);
    end
    step("to_drop", S_DROP, 1'b1);
    step("to_drop_hold", S_DROP, 1'b0);
    pkt_valid = 1'b0;
    step("to_exit", S_DA, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_fsm_np.md
Name: router_fsm_np

Overview:
Parametrised control FSM for a 1xN packet router. It is the successor of the fixed 3-port router FSM.
- Decodes the header address and sequences the header, payload and parity loads into the register/synchroniser path.
- Handles destination-FIFO-full stalls and per-port soft resets.
- New behaviour: drops packets addressed to non-existent ports, and exposes a latched one-hot destination select for the synchroniser.

Parameters:
NUM_PORTS, 3, number of output ports/FIFOs (2..16)
ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= NUM_PORTS
WAIT_TIMEOUT, 64, cycles allowed in WAIT_TILL_EMPTY before drop (used only with the optional feature)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
pkt_valid  in  1  source asserts for the duration of header and payload
data_in  in  ADDR_W  address field of the current header byte
parity_done  in  1  register block has finished parity capture
low_pkt_valid  in  1  register block saw pkt_valid fall after a full stall
fifo_full  in  1  full flag of the currently selected FIFO (muxed by synchroniser)
fifo_empty  in  NUM_PORTS  per-FIFO empty flags
soft_reset  in  NUM_PORTS  per-FIFO soft-reset pulses from the synchroniser
busy  out  1  source must hold data
detect_add  out  1  in DECODE_ADDRESS
lfd_state  out  1  in LOAD_FIRST_DATA
ld_state  out  1  in LOAD_DATA
laf_state  out  1  in LOAD_AFTER_FULL
full_state  out  1  in FIFO_FULL_STATE
write_enb_reg  out  1  register block may write to FIFO
rst_int_reg  out  1  in CHECK_PARITY_ERROR
dest_sel  out  NUM_PORTS  one-hot latched destination
pkt_drop  out  1  one-cycle pulse on entry to DROP_PACKET

Behaviour:
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, WAIT_TILL_EMPTY, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, DROP_PACKET.
- Reset (synchronous, highest priority):
  - state=DECODE_ADDRESS, dest_sel=0, timeout counter=0.
  - Outputs after reset: detect_add=1, all other outputs 0.
- All state outputs are Moore (decoded from the state register). pkt_drop is registered.
- Address decode (DECODE_ADDRESS with pkt_valid=1):
  - addr = data_in. The address is valid iff addr < NUM_PORTS.
  - On a valid address, dest_sel is loaded with a one-hot encoding of addr in the same edge as the transition.
  - dest_sel holds until the next decode or reset.
- Transitions:
  - DECODE_ADDRESS:
    - pkt_valid & valid & fifo_empty[addr] -> LOAD_FIRST_DATA
    - pkt_valid & valid & !fifo_empty[addr] -> WAIT_TILL_EMPTY
    - pkt_valid & invalid -> DROP_PACKET
    - otherwise stay
  - LOAD_FIRST_DATA -> LOAD_DATA (unconditional, 1 cycle).
  - WAIT_TILL_EMPTY: fifo_empty at the dest_sel index -> LOAD_FIRST_DATA; else stay.
  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
  - DROP_PACKET: !pkt_valid -> DECODE_ADDRESS; else stay.
- Soft reset:
  - If soft_reset at the dest_sel index is 1 in any state other than DECODE_ADDRESS and DROP_PACKET, next state is DECODE_ADDRESS.
  - Soft reset takes priority over all normal transitions.
  - soft_reset bits for non-selected ports are ignored.
- Output decode:
  - busy=1 in LOAD_FIRST_DATA, WAIT_TILL_EMPTY, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR.
  - busy=0 in DECODE_ADDRESS, LOAD_DATA and DROP_PACKET; the source streams freely while a packet is dropped.
  - write_enb_reg=1 in LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY; write_enb_reg=0 in DROP_PACKET.
- pkt_drop=1 for exactly the first cycle spent in DROP_PACKET.
- Header-to-first-write latency: 1 cycle to LOAD_FIRST_DATA when the FIFO is empty.
- Simultaneous events:
  - reset > soft_reset > normal transitions.
  - fifo_full together with !pkt_valid in LOAD_DATA -> FIFO_FULL_STATE.
  - parity_done together with low_pkt_valid in LOAD_AFTER_FULL -> DECODE_ADDRESS.

Optional Feature:
ROUTER_WAIT_TIMEOUT_EN:
- Defined:
  - A counter of width clog2(WAIT_TIMEOUT+1) clears on entry to WAIT_TILL_EMPTY and increments each cycle spent there.
  - When it reaches WAIT_TIMEOUT-1 and the FIFO is still non-empty, next state is DROP_PACKET and pkt_drop pulses.
  - If fifo_empty rises on the terminal cycle, LOAD_FIRST_DATA wins.
- Undefined: no counter is instantiated, WAIT_TILL_EMPTY waits indefinitely, and WAIT_TIMEOUT is unused.

Test Plan:
- Reset then header addr=1, fifo_empty=3'b010, pkt_valid high 3 cycles then low -> DECODE→LFD→LD(×2)→LP→CPE→DECODE; dest_sel=3'b010; write_enb_reg high in LD/LP only.
- In LD raise fifo_full for 2 cycles, then drop it with pkt_valid=1 -> FFS(×2)→LAF→LD; busy=1 during FFS/LAF; write_enb_reg=0 in FFS.
- NUM_PORTS=3, header addr=3 with pkt_valid high 4 cycles -> pkt_drop single pulse, DROP_PACKET until pkt_valid falls, then DECODE; busy=0 and write_enb_reg=0 throughout.
- Header addr=2 with fifo_empty[2]=0 for 5 cycles then 1 -> WAIT_TILL_EMPTY for 5 cycles, then LFD; busy=1 while waiting.
- Mid-packet (LD, dest 0): soft_reset=3'b010 -> no effect; then soft_reset=3'b001 -> DECODE next cycle; reset asserted in FFS -> DECODE, dest_sel=0.
- With ROUTER_WAIT_TIMEOUT_EN, WAIT_TIMEOUT=4, FIFO never empties -> DROP_PACKET after exactly 4 WAIT_TILL_EMPTY cycles, pkt_drop=1 once.
